// File: rtl/i281_pkg.sv
// Shared i281 definitions: datapath widths, fetch FSM states and instruction field positions.
package i281_pkg;

  localparam int PC_W    = 5;
  localparam int INSTR_W = 17;

  typedef enum logic [1:0] {
    ST_ADDR   = 2'd0,
    ST_CAPT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Instruction field slices, consumed by decode; fetch passes words through untouched.
  localparam int SPARE_BIT = 16;
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RA_MSB    = 11;
  localparam int RA_LSB    = 10;
  localparam int RB_MSB    = 9;
  localparam int RB_LSB    = 8;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/i281_fetch_unit.sv
// i281 instruction fetch: pc, instruction register and valid/ready hand-off to decode.
// Optional fetched-instruction counter port enabled by defining I281_FETCH_PERF_EN.
module i281_fetch_unit
  import i281_pkg::*;
#(
  parameter int PC_W    = i281_pkg::PC_W,
  parameter int INSTR_W = i281_pkg::INSTR_W
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt
`ifdef I281_FETCH_PERF_EN
 ,output logic [15:0]        fetch_count
`endif
);

  fetch_state_e       state_r;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    ir_pc_r;
  logic [INSTR_W-1:0] ir_r;
  logic               ir_valid_r;
  logic               xfer_s;

  assign xfer_s    = ir_valid_r & ir_ready;
  assign imem_addr = pc_r;
  assign ir        = ir_r;
  assign ir_pc     = ir_pc_r;
  assign ir_valid  = ir_valid_r;

  // Fetch FSM with pc, ir, ir_pc and ir_valid registers; redirect outranks every other update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_ADDR;
      pc_r       <= {PC_W{1'b0}};
      ir_pc_r    <= {PC_W{1'b0}};
      ir_r       <= {INSTR_W{1'b0}};
      ir_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (redirect_valid) begin
            pc_r <= redirect_pc;
          end else if (halt) begin
            state_r <= ST_HALTED;
          end else begin
            state_r <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          // A redirect here drops the word coming back from memory; ir keeps its old contents.
          if (redirect_valid) begin
            pc_r       <= redirect_pc;
            ir_valid_r <= 1'b0;
            state_r    <= ST_ADDR;
          end else begin
            ir_r       <= imem_data;
            ir_pc_r    <= pc_r;
            pc_r       <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            ir_valid_r <= 1'b1;
            state_r    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc_r       <= redirect_pc;
            ir_valid_r <= 1'b0;
            state_r    <= ST_ADDR;
          end else if (xfer_s) begin
            ir_valid_r <= 1'b0;
            state_r    <= halt ? ST_HALTED : ST_ADDR;
          end else begin
            ir_valid_r <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (redirect_valid) begin
            pc_r <= redirect_pc;
          end else if (!halt) begin
            state_r <= ST_ADDR;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        default: begin
          state_r    <= ST_ADDR;
          ir_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef I281_FETCH_PERF_EN
  logic [15:0] fetch_count_r;
  logic        capt_ok_s;

  assign capt_ok_s   = (state_r == ST_CAPT) & ~redirect_valid;
  assign fetch_count = fetch_count_r;

  // Saturating count of completed captures.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_r <= 16'd0;
    end else if (capt_ok_s && (fetch_count_r != 16'hFFFF)) begin
      fetch_count_r <= fetch_count_r + 16'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end
`endif

endmodule

// File: tb/tb_i281_fetch_unit.sv
// Self-checking bench for i281_fetch_unit: directed vector table, async reset sequence and
// randomized traffic against a rule-level reference model (count checked with I281_FETCH_PERF_EN).
module tb_i281_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic [4:0]  imem_addr;
  logic [16:0] imem_data;
  logic [16:0] ir;
  logic [4:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        halt;
`ifdef I281_FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [16:0] mem [32];

  i281_fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef I281_FETCH_PERF_EN
   ,.fetch_count    (fetch_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous code memory: data for an address appears the cycle after it is presented.
  always_ff @(posedge clock) imem_data <= mem[imem_addr];

  // Reference model: tracks what has been fetched by the rules, not by FSM encoding.
  int          m_pc, m_irpc, m_age, m_cnt;
  logic [16:0] m_ir;
  bit          m_valid, m_halted;

  task automatic model_reset();
    m_pc = 0; m_irpc = 0; m_age = 0; m_cnt = 0;
    m_ir = 17'd0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step();
    bit xfer;
    xfer = m_valid && ir_ready;
    if (m_halted) begin
      if (redirect_valid) m_pc = int'(redirect_pc);
      else if (!halt) begin m_halted = 1'b0; m_age = 0; end
    end else if (redirect_valid) begin
      m_pc = int'(redirect_pc); m_valid = 1'b0; m_age = 0;
    end else if (m_valid) begin
      if (xfer) begin m_valid = 1'b0; m_age = 0; m_halted = halt; end
    end else if (m_age == 0) begin
      if (halt) m_halted = 1'b1; else m_age = 1;
    end else begin
      m_ir = mem[m_pc]; m_irpc = m_pc; m_pc = (m_pc + 1) % 32; m_valid = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model ir_valid", 32'(ir_valid), 32'(m_valid));
    chk("model ir", 32'(ir), 32'(m_ir));
    chk("model ir_pc", 32'(ir_pc), 32'(m_irpc));
    chk("model imem_addr", 32'(imem_addr), 32'(m_pc));
`ifdef I281_FETCH_PERF_EN
    chk("model fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
  endtask

  // One clock: model advances on the same inputs the DUT samples; outputs checked 1 ns after the edge.
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare_model();
    @(negedge clock);
  endtask

  typedef struct {
    logic       ready;
    logic       redir;
    logic [4:0] rpc;
    logic       hlt;
    logic       exp_valid;
    logic [4:0] exp_irpc;
    logic [4:0] exp_addr;
  } vec_t;

  vec_t        tbl [24];
  logic [16:0] last_ir;

  initial begin
    reset_n = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 5'd0; halt = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 17'($urandom);
    mem[0] = 17'b0_0011_00_00_00000000;

    // ready, redirect, target, halt | ir_valid, ir_pc, imem_addr after the edge
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0};
    tbl[1]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  5'd1};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd1};
    tbl[3]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  5'd1};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  5'd2};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  5'd2};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  5'd2};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  5'd2};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  5'd2};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  5'd2};
    tbl[10] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd1,  5'd2};
    tbl[11] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd1,  5'd2};
    tbl[12] = '{1'b1, 1'b1, 5'd14, 1'b0, 1'b0, 5'd1,  5'd14};
    tbl[13] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd1,  5'd14};
    tbl[14] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd14, 5'd15};
    tbl[15] = '{1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 5'd14, 5'd31};
    tbl[16] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd14, 5'd31};
    tbl[17] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd31, 5'd0};
    tbl[18] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd31, 5'd0};
    tbl[19] = '{1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 5'd31, 5'd5};
    tbl[20] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd31, 5'd5};
    tbl[21] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd31, 5'd5};
    tbl[22] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd31, 5'd5};
    tbl[23] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd5,  5'd6};

    repeat (2) @(posedge clock);
    #1;
    chk("reset ir", 32'(ir), 32'd0);
    chk("reset ir_valid", 32'(ir_valid), 32'd0);
    chk("reset imem_addr", 32'(imem_addr), 32'd0);
    chk("reset ir_pc", 32'(ir_pc), 32'd0);
`ifdef I281_FETCH_PERF_EN
    chk("reset fetch_count", 32'(fetch_count), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();

    last_ir = 17'd0;
    for (int r = 0; r < 24; r++) begin
      ir_ready = tbl[r].ready; redirect_valid = tbl[r].redir;
      redirect_pc = tbl[r].rpc; halt = tbl[r].hlt;
      step();
      if (tbl[r].exp_valid) last_ir = mem[tbl[r].exp_irpc];
      chk($sformatf("tbl[%0d] ir_valid", r), 32'(ir_valid), 32'(tbl[r].exp_valid));
      chk($sformatf("tbl[%0d] ir_pc", r), 32'(ir_pc), 32'(tbl[r].exp_irpc));
      chk($sformatf("tbl[%0d] imem_addr", r), 32'(imem_addr), 32'(tbl[r].exp_addr));
      chk($sformatf("tbl[%0d] ir", r), 32'(ir), 32'(last_ir));
    end

    // Asynchronous reset while holding a valid instruction, away from any clock edge.
    redirect_valid = 1'b0; halt = 1'b0; ir_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async ir", 32'(ir), 32'd0);
    chk("async ir_valid", 32'(ir_valid), 32'd0);
    chk("async imem_addr", 32'(imem_addr), 32'd0);
    chk("async ir_pc", 32'(ir_pc), 32'd0);
`ifdef I281_FETCH_PERF_EN
    chk("async fetch_count", 32'(fetch_count), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    ir_ready = 1'b1;
    repeat (8) step();
    chk("three fetches ir_pc", 32'(ir_pc), 32'd2);
    chk("three fetches ir", 32'(ir), 32'(mem[2]));
`ifdef I281_FETCH_PERF_EN
    chk("three fetches fetch_count", 32'(fetch_count), 32'd3);
`endif

    for (int n = 0; n < 600; n++) begin
      ir_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 5'($urandom_range(0, 31));
      halt           = ($urandom_range(0, 6) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
